// File: rtl/instr_encoder.sv
// RV32I word assembler for the loader subset (mv/sw/jal/jalr/branch).
// Requests are encoded combinationally, buffered in a small FIFO and drained as sequential word writes.
module instr_encoder #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_imme,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_flag,
  output logic [7:0]        err_cnt
);

  // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
  // a word transfers on the rising edge where wr_valid && wr_ready.

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [2:0] OP_MV     = 3'd0;
  localparam logic [2:0] OP_SW     = 3'd1;
  localparam logic [2:0] OP_JAL    = 3'd2;
  localparam logic [2:0] OP_JALR   = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] ptr_diff;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic             drop;
  logic             legal;
  logic [31:0]      enc_word;
  logic             imm_fits_12;
  logic             imm_fits_21;
  logic             imm_fits_13;

  assign ptr_diff  = wr_ptr - rd_ptr;
  assign full      = (ptr_diff == PTR_W'(FIFO_DEPTH));
  assign empty     = (wr_ptr == rd_ptr);
  assign req_ready = !full && !restart;
  assign wr_valid  = !empty;
  assign wr_data   = wr_valid ? mem[rd_ptr[IDX_W-1:0]] : 32'd0;

  assign accept = req_valid && req_ready;
  assign push   = accept && legal;
  assign drop   = accept && !legal;
  assign pop    = wr_valid && wr_ready && !restart;

  // Sign-extension checks: the dropped upper bits must all match the top kept bit.
  assign imm_fits_12 = (&req_imme[31:11]) || !(|req_imme[31:11]);
  assign imm_fits_21 = (&req_imme[31:20]) || !(|req_imme[31:20]);
  assign imm_fits_13 = (&req_imme[31:12]) || !(|req_imme[31:12]);

  always_comb begin
    enc_word = 32'd0;
    legal    = 1'b0;
    case (req_op)
      OP_MV: begin
        enc_word = {12'b0, req_rs1, 3'b000, req_rd, 7'b0010011};
        legal    = 1'b1;
      end
      OP_SW: begin
        enc_word = {req_imme[11:5], req_rs2, req_rs1, 3'b010, req_imme[4:0], 7'b0100011};
        legal    = imm_fits_12;
      end
      OP_JAL: begin
        enc_word = {req_imme[20], req_imme[10:1], req_imme[11], req_imme[19:12],
                    req_rd, 7'b1101111};
        legal    = imm_fits_21 && !req_imme[0];
      end
      OP_JALR: begin
        enc_word = {req_imme[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
        legal    = imm_fits_12;
      end
      OP_BRANCH: begin
        enc_word = {req_imme[12], req_imme[10:5], req_rs2, req_rs1, req_func3,
                    req_imme[4:1], req_imme[11], 7'b1100011};
        // func3 010/011 are not branch conditions in RV32I.
        legal    = imm_fits_13 && !req_imme[0] && (req_func3[2:1] != 2'b01);
      end
      default: begin
        enc_word = 32'd0;
        legal    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_addr  <= BASE_ADDR;
      err_flag <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (restart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_addr  <= BASE_ADDR;
      err_flag <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        wr_addr <= wr_addr + ADDR_W'(4);
      end
      if (drop) begin
        err_flag <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, legality drops, error saturation,
// back-pressure, restart, address wrap (narrow instance) and async reset.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        restart;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_func3;
  logic [31:0] req_imme;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        err_flag;
  logic [7:0]  err_cnt;

  logic        req_ready2;
  logic        wr_valid2;
  logic [3:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic        err_flag2;
  logic [7:0]  err_cnt2;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_func3(req_func3), .req_imme(req_imme),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'd12)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready2), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_func3(req_func3), .req_imme(req_imme),
    .wr_valid(wr_valid2), .wr_ready(wr_ready), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .err_flag(err_flag2), .err_cnt(err_cnt2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    bit done;
    done      = 1'b0;
    req_op    = op;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_func3 = f3;
    req_imme  = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart  = 1'b0;
    exp_q.delete();
    exp_addr = 32'd0;
  endtask

  // Scoreboard: every observed write must match the head of exp_q at the model address.
  always @(negedge clk) begin
    if (rst_n && !restart && wr_valid && wr_ready) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("wr_data", wr_data, exp_q.pop_front());
        check("wr_addr", wr_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_addr  = 32'd0;
    rst_n     = 1'b0;
    restart   = 1'b0;
    req_valid = 1'b0;
    wr_ready  = 1'b1;
    req_op    = 3'd0;
    req_rd    = 5'd0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    req_func3 = 3'd0;
    req_imme  = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_narrow_addr", 32'(wr_addr2), 32'd12);
    @(posedge clk); #1;

    // Legal encodings, draining freely
    exp_q.push_back(32'h0003_0293);
    send(3'd0, 5'd5, 5'd6, 5'd0, 3'd0, 32'h123);
    @(negedge clk);
    check("mv_latency_valid", 32'(wr_valid), 32'd1);
    check("narrow_first_addr", 32'(wr_addr2), 32'd12);
    @(posedge clk); #1;
    exp_q.push_back(32'h0021_A423);
    send(3'd1, 5'd0, 5'd3, 5'd2, 3'd0, 32'd8);
    @(negedge clk);
    check("narrow_wrap_addr", 32'(wr_addr2), 32'd0);
    check("narrow_wrap_data", wr_data2, 32'h0021_A423);
    @(posedge clk); #1;
    exp_q.push_back(32'h0080_00EF);
    send(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
    exp_q.push_back(32'hFE20_8EE3);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_8067);
    send(3'd3, 5'd0, 5'd1, 5'd0, 3'd0, 32'd0);
    exp_q.push_back(32'h8000_2023);
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800);
    wait_drain();

    // Dropped requests
    send(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    check("err_flag_set", 32'(err_flag), 32'd1);
    check("err_cnt_jal", 32'(err_cnt), 32'd1);
    check("no_write_after_drop", 32'(wr_valid), 32'd0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8);
    check("err_cnt_branch", 32'(err_cnt), 32'd2);
    send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
    check("err_cnt_op6", 32'(err_cnt), 32'd3);
    send(3'd1, 5'd0, 5'd3, 5'd2, 3'd0, 32'd2048);
    check("err_cnt_sw_range", 32'(err_cnt), 32'd4);
    for (int i = 0; i < 296; i++) send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    check("err_cnt_saturate", 32'(err_cnt), 32'd255);
    check("sat_no_write", 32'(wr_valid), 32'd0);

    // Restart with 3 words queued and a request pending
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      send(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 32'd0);
    end
    req_op    = 3'd0;
    req_valid = 1'b1;
    restart   = 1'b1;
    @(negedge clk);
    check("ready_during_restart", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    restart   = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    exp_addr  = 32'd0;
    @(negedge clk);
    check("restart_wr_valid", 32'(wr_valid), 32'd0);
    check("restart_wr_addr", wr_addr, 32'd0);
    check("restart_err_flag", 32'(err_flag), 32'd0);
    check("restart_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    exp_q.push_back(32'h0003_8313);
    send(3'd0, 5'd6, 5'd7, 5'd0, 3'd0, 32'd0);
    wait_drain();

    // Back-pressure: fill, then release
    do_restart();
    wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({12'b0, 5'(i), 3'b000, 5'(i), 7'b0010011});
      send(3'd0, 5'(i), 5'(i), 5'd0, 3'd0, 32'd0);
    end
    @(negedge clk);
    check("full_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(negedge clk);
    check("no_ready_before_pop", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_pop", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // Async reset mid-drain
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    check("pre_reset_err_cnt", 32'(err_cnt), 32'd1);
    wr_ready = 1'b0;
    exp_q.push_back(32'd0);
    send(3'd0, 5'd2, 5'd2, 5'd0, 3'd0, 32'd0);
    exp_q.push_back(32'd0);
    send(3'd0, 5'd3, 5'd3, 5'd0, 3'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_wr_valid", 32'(wr_valid), 32'd0);
    check("async_wr_addr", wr_addr, 32'd0);
    check("async_wr_data", wr_data, 32'd0);
    check("async_err_flag", 32'(err_flag), 32'd0);
    check("async_err_cnt", 32'(err_cnt), 32'd0);
    check("async_narrow_addr", 32'(wr_addr2), 32'd12);
    exp_q.delete();
    exp_addr = 32'd0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    exp_q.push_back(32'h0003_0293);
    send(3'd0, 5'd5, 5'd6, 5'd0, 3'd0, 32'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
